vx_mem_width_adapter: RTL and testbench
=======================================

Name: vx_mem_width_adapter

Overview:
- Sits between the Vortex top-level memory port and an external memory channel whose data bus is narrower than the cache line.
- Splits each line-wide request into RATIO = SRC_DATA_WIDTH/DST_DATA_WIDTH sequential narrow beats.
- Reassembles in-order narrow read responses into one line-wide response carrying the original tag.
- Limits outstanding line reads and exposes a busy flag that is ORed into system busy.

Parameters:
- SRC_DATA_WIDTH, 512: line-side data width; RATIO = SRC_DATA_WIDTH/DST_DATA_WIDTH, a power of 2, >= 2.
- SRC_ADDR_WIDTH, 26: line-side address width, in line units.
- DST_DATA_WIDTH, 128: memory-side data width.
- TAG_WIDTH, 8: line-side tag width.
- MAX_PENDING, 4: maximum outstanding line reads, >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- src_req_valid / src_req_rw  in  1 / 1  line request valid; rw=1 is a write
- src_req_byteen  in  SRC_DATA_WIDTH/8  byte enables
- src_req_addr  in  SRC_ADDR_WIDTH  line address
- src_req_data  in  SRC_DATA_WIDTH  write data
- src_req_tag  in  TAG_WIDTH  request tag
- src_req_ready  out  1  request accepted
- src_rsp_valid / src_rsp_data / src_rsp_tag  out  1 / SRC_DATA_WIDTH / TAG_WIDTH  assembled line read response
- src_rsp_ready  in  1  response consumed
- dst_req_valid / dst_req_rw  out  1 / 1  beat request
- dst_req_byteen  out  DST_DATA_WIDTH/8  beat byte enables
- dst_req_addr  out  SRC_ADDR_WIDTH+log2(RATIO)  beat address
- dst_req_data  out  DST_DATA_WIDTH  beat write data
- dst_req_tag  out  TAG_WIDTH+log2(RATIO)  {src_tag, beat_idx}
- dst_req_ready  in  1  beat accepted
- dst_rsp_valid / dst_rsp_data / dst_rsp_tag  in  1 / DST_DATA_WIDTH / TAG_WIDTH+log2(RATIO)  beat read response
- dst_rsp_ready  out  1  beat consumed
- busy  out  1  activity in flight

Behaviour:
- Reset (async, active-high): state=IDLE, beat=0, pending=0, assembly count=0, src_rsp_valid=0, dst_req_valid=0, busy=0. Mid-operation reset discards all in-flight beats and the partial line; no response is produced.
- Request FSM, IDLE:
  - src_req_ready = (pending < MAX_PENDING) | src_req_rw, combinational.
  - On src fire: latch rw/addr/data/byteen/tag, beat=0, state=SPLIT.
  - A write with all-zero byteen is accepted and dropped, FSM stays IDLE.
  - A read fire increments pending.
- Request FSM, SPLIT:
  - src_req_ready=0.
  - dst_req_addr = {addr, beat}; dst_req_data = data slice[beat]; dst_req_tag = {tag, beat}.
  - Reads: dst_req_byteen all ones, every beat issued.
  - Writes: byteen = slice[beat]; beats with zero byteen slice are skipped (beat advances without issuing, one cycle per skipped beat, dst_req_valid=0).
  - On dst fire or skip: beat++. On the last beat (beat==RATIO-1) return to IDLE. No overlap with the next src request, so there is a one-cycle IDLE bubble.
  - dst_req_valid and payload are held stable while dst_req_ready=0.
- Response path:
  - dst_rsp_ready = !src_rsp_valid.
  - On dst_rsp fire: store data at slice[cnt], cnt++. dst_rsp_tag beat field must equal cnt (simulation assertion on mismatch).
  - Memory returns beats in request order.
  - When cnt reaches RATIO: src_rsp_valid=1 next cycle, src_rsp_tag = upper TAG_WIDTH bits of the last beat tag, cnt wraps to 0.
  - src_rsp_data/tag are held until src_rsp_ready. On fire, valid clears; the next dst beat is accepted the following cycle.
- pending: +1 on read src fire, -1 on src_rsp fire; a simultaneous inc and dec leaves it unchanged. Never exceeds MAX_PENDING; underflow is an assertion.
- busy = (state != IDLE) | (pending != 0) | src_rsp_valid, registered-source, combinational OR.
- Write requests produce no src response.

Test Plan:
- Read (RATIO=4) addr 0x10, tag 0x05, dst_req_ready=1:
  - Expect dst beats addr 0x40..0x43, tags 0x14..0x17, byteen 0xFFFF.
  - Return D0..D3 with matching tags; expect src_rsp data {D3,D2,D1,D0}, tag 0x05, one cycle after the last beat.
- Write addr 0x2, byteen with only slices 1 and 3 nonzero:
  - Exactly two dst writes: addr 0x09, 0x0B with their data slices.
  - No src_rsp; busy=0 after return to IDLE.
- MAX_PENDING=2, three back-to-back reads, no responses: third src_req_ready stays 0 until the first src_rsp fires, then it is accepted.
- Backpressure:
  - dst_req_ready toggling 1/0: beats issue in order, payload stable while stalled.
  - src_rsp_ready=0 after a full line: dst_rsp_ready=0, src_rsp_data unchanged for 10 cycles.
- Reset asserted after 2 of 4 read beats:
  - Outputs go to reset values immediately, busy=0.
  - The next read starts at beat 0 with pending=1.
- pending=1: a read fire and src_rsp fire in the same cycle leave pending=1; busy stays 1.

Source files
------------

// File: rtl/vx_mem_width_adapter.sv
// vx_mem_width_adapter
//
// Bridges the line-wide Vortex memory port to a narrower external memory channel.
// Each line request is split into RATIO = SRC_DATA_WIDTH / DST_DATA_WIDTH narrow beats,
// issued in order. In-order narrow read responses are reassembled into a single line
// response that carries the original tag. Outstanding line reads are capped at MAX_PENDING.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   src_req_*                  line-side request (valid/ready, rw=1 write)
//   src_rsp_*                  line-side assembled read response (valid/ready)
//   dst_req_*                  memory-side beat request; addr = {line_addr, beat}, tag = {tag, beat}
//   dst_rsp_*                  memory-side beat read response, returned in request order
//   busy                       any request splitting, read outstanding or response held

module vx_mem_width_adapter #(
  parameter int unsigned SRC_DATA_WIDTH = 512,
  parameter int unsigned SRC_ADDR_WIDTH = 26,
  parameter int unsigned DST_DATA_WIDTH = 128,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned MAX_PENDING    = 4
) (
  input  logic                                                   clk,
  input  logic                                                   reset,

  input  logic                                                   src_req_valid,
  input  logic                                                   src_req_rw,
  input  logic [SRC_DATA_WIDTH/8-1:0]                            src_req_byteen,
  input  logic [SRC_ADDR_WIDTH-1:0]                              src_req_addr,
  input  logic [SRC_DATA_WIDTH-1:0]                              src_req_data,
  input  logic [TAG_WIDTH-1:0]                                   src_req_tag,
  output logic                                                   src_req_ready,

  output logic                                                   src_rsp_valid,
  output logic [SRC_DATA_WIDTH-1:0]                              src_rsp_data,
  output logic [TAG_WIDTH-1:0]                                   src_rsp_tag,
  input  logic                                                   src_rsp_ready,

  output logic                                                   dst_req_valid,
  output logic                                                   dst_req_rw,
  output logic [DST_DATA_WIDTH/8-1:0]                            dst_req_byteen,
  output logic [SRC_ADDR_WIDTH+$clog2(SRC_DATA_WIDTH/DST_DATA_WIDTH)-1:0] dst_req_addr,
  output logic [DST_DATA_WIDTH-1:0]                              dst_req_data,
  output logic [TAG_WIDTH+$clog2(SRC_DATA_WIDTH/DST_DATA_WIDTH)-1:0] dst_req_tag,
  input  logic                                                   dst_req_ready,

  input  logic                                                   dst_rsp_valid,
  input  logic [DST_DATA_WIDTH-1:0]                              dst_rsp_data,
  input  logic [TAG_WIDTH+$clog2(SRC_DATA_WIDTH/DST_DATA_WIDTH)-1:0] dst_rsp_tag,
  output logic                                                   dst_rsp_ready,

  output logic                                                   busy
);

  localparam int unsigned RATIO    = SRC_DATA_WIDTH / DST_DATA_WIDTH;
  localparam int unsigned BEAT_W   = $clog2(RATIO);
  localparam int unsigned SRC_BE_W = SRC_DATA_WIDTH / 8;
  localparam int unsigned DST_BE_W = DST_DATA_WIDTH / 8;
  localparam int unsigned PEND_W   = $clog2(MAX_PENDING + 1);

  localparam logic [BEAT_W-1:0] LastBeat   = BEAT_W'(RATIO - 1);
  localparam logic [PEND_W-1:0] PendingMax = PEND_W'(MAX_PENDING);

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  // Request side state
  state_e                    state_q,  state_d;
  logic [BEAT_W-1:0]         beat_q,   beat_d;
  logic                      rw_q,     rw_d;
  logic [SRC_ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [SRC_DATA_WIDTH-1:0] data_q,   data_d;
  logic [SRC_BE_W-1:0]       byteen_q, byteen_d;
  logic [TAG_WIDTH-1:0]      tag_q,    tag_d;

  // Response side state
  logic [PEND_W-1:0]         pending_q,   pending_d;
  logic [BEAT_W-1:0]         cnt_q,       cnt_d;
  logic [SRC_DATA_WIDTH-1:0] asm_q,       asm_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]      rsp_tag_q,   rsp_tag_d;

  logic                      src_fire;
  logic                      dst_fire;
  logic                      rsp_fire;
  logic                      src_rsp_fire;
  logic                      skip;
  logic [DST_BE_W-1:0]       beat_be;
  logic [DST_DATA_WIDTH-1:0] beat_data;
  logic                      pend_inc;
  logic                      pend_dec;

  // Current beat slices of the latched line
  always_comb begin
    beat_be   = byteen_q[int'(beat_q) * DST_BE_W +: DST_BE_W];
    beat_data = data_q[int'(beat_q) * DST_DATA_WIDTH +: DST_DATA_WIDTH];
  end

  // Request-side outputs
  always_comb begin
    // Write beats with no enabled bytes are walked past without touching memory
    skip           = (state_q == StSplit) & rw_q & (beat_be == '0);
    src_req_ready  = (state_q == StIdle) & ((pending_q < PendingMax) | src_req_rw);
    dst_req_valid  = (state_q == StSplit) & ~skip;
    dst_req_rw     = rw_q;
    dst_req_addr   = {addr_q, beat_q};
    dst_req_data   = beat_data;
    dst_req_tag    = {tag_q, beat_q};
    dst_req_byteen = rw_q ? beat_be : '1;
    src_fire       = src_req_valid & src_req_ready;
    dst_fire       = dst_req_valid & dst_req_ready;
  end

  // Request FSM next state
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    byteen_d = byteen_q;
    tag_d    = tag_q;

    unique case (state_q)
      StIdle: begin
        // A write with nothing enabled is accepted and dropped
        if (src_fire && !(src_req_rw && (src_req_byteen == '0))) begin
          rw_d     = src_req_rw;
          addr_d   = src_req_addr;
          data_d   = src_req_data;
          byteen_d = src_req_byteen;
          tag_d    = src_req_tag;
          beat_d   = '0;
          state_d  = StSplit;
        end
      end
      StSplit: begin
        if (dst_fire || skip) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response reassembly and pending tracking
  always_comb begin
    dst_rsp_ready = ~rsp_valid_q;
    src_rsp_valid = rsp_valid_q;
    src_rsp_data  = asm_q;
    src_rsp_tag   = rsp_tag_q;
    rsp_fire      = dst_rsp_valid & ~rsp_valid_q;
    src_rsp_fire  = rsp_valid_q & src_rsp_ready;

    cnt_d       = cnt_q;
    asm_d       = asm_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;

    if (rsp_fire) begin
      asm_d[int'(cnt_q) * DST_DATA_WIDTH +: DST_DATA_WIDTH] = dst_rsp_data;
      cnt_d = cnt_q + BEAT_W'(1);
      if (cnt_q == LastBeat) begin
        rsp_valid_d = 1'b1;
        rsp_tag_d   = dst_rsp_tag[TAG_WIDTH+BEAT_W-1:BEAT_W];
      end
    end
    // The line cannot complete while a response is held, so these never collide
    if (src_rsp_fire) begin
      rsp_valid_d = 1'b0;
    end

    pend_inc  = src_fire & ~src_req_rw;
    pend_dec  = src_rsp_fire;
    pending_d = pending_q;
    unique case ({pend_inc, pend_dec})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase

    busy = (state_q != StIdle) | (pending_q != '0) | rsp_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      byteen_q    <= '0;
      tag_q       <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      byteen_q    <= byteen_d;
      tag_q       <= tag_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

`ifndef SYNTHESIS
  // Memory must return beats in order, and responses must match an outstanding read
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (rsp_fire) begin
        assert (dst_rsp_tag[BEAT_W-1:0] == cnt_q);
      end
      if (pend_dec && !pend_inc) begin
        assert (pending_q != '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_width_adapter.sv
// Directed bench for vx_mem_width_adapter with RATIO=4 (512/128) and MAX_PENDING=2.

module tb_vx_mem_width_adapter;

  logic         clk;
  logic         reset;
  logic         src_req_valid;
  logic         src_req_rw;
  logic [63:0]  src_req_byteen;
  logic [25:0]  src_req_addr;
  logic [511:0] src_req_data;
  logic [7:0]   src_req_tag;
  logic         src_req_ready;
  logic         src_rsp_valid;
  logic [511:0] src_rsp_data;
  logic [7:0]   src_rsp_tag;
  logic         src_rsp_ready;
  logic         dst_req_valid;
  logic         dst_req_rw;
  logic [15:0]  dst_req_byteen;
  logic [27:0]  dst_req_addr;
  logic [127:0] dst_req_data;
  logic [9:0]   dst_req_tag;
  logic         dst_req_ready;
  logic         dst_rsp_valid;
  logic [127:0] dst_rsp_data;
  logic [9:0]   dst_rsp_tag;
  logic         dst_rsp_ready;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  vx_mem_width_adapter #(
    .SRC_DATA_WIDTH(512),
    .SRC_ADDR_WIDTH(26),
    .DST_DATA_WIDTH(128),
    .TAG_WIDTH     (8),
    .MAX_PENDING   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_req_valid (src_req_valid),
    .src_req_rw    (src_req_rw),
    .src_req_byteen(src_req_byteen),
    .src_req_addr  (src_req_addr),
    .src_req_data  (src_req_data),
    .src_req_tag   (src_req_tag),
    .src_req_ready (src_req_ready),
    .src_rsp_valid (src_rsp_valid),
    .src_rsp_data  (src_rsp_data),
    .src_rsp_tag   (src_rsp_tag),
    .src_rsp_ready (src_rsp_ready),
    .dst_req_valid (dst_req_valid),
    .dst_req_rw    (dst_req_rw),
    .dst_req_byteen(dst_req_byteen),
    .dst_req_addr  (dst_req_addr),
    .dst_req_data  (dst_req_data),
    .dst_req_tag   (dst_req_tag),
    .dst_req_ready (dst_req_ready),
    .dst_rsp_valid (dst_rsp_valid),
    .dst_rsp_data  (dst_rsp_data),
    .dst_rsp_tag   (dst_rsp_tag),
    .dst_rsp_ready (dst_rsp_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] bd(input logic [31:0] s, input int i);
    return {s, 32'hC0FFEE00 + 32'(i), ~s, 32'h12340000 | 32'(i)};
  endfunction

  function automatic logic [511:0] line(input logic [31:0] s);
    return {bd(s, 3), bd(s, 2), bd(s, 1), bd(s, 0)};
  endfunction

  // Issue one read and walk its four beats with dst_req_ready held high
  task automatic do_read(input logic [25:0] a, input logic [7:0] t);
    logic [1:0] b;
    src_req_valid  = 1'b1;
    src_req_rw     = 1'b0;
    src_req_addr   = a;
    src_req_tag    = t;
    src_req_byteen = '1;
    #1;
    check_eq("rd_accept", 512'(src_req_ready), 512'(1));
    step();
    src_req_valid = 1'b0;
    dst_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 2'(i);
      #1;
      check_eq("rd_beat_valid", 512'(dst_req_valid), 512'(1));
      check_eq("rd_beat_addr", 512'(dst_req_addr), 512'({a, b}));
      check_eq("rd_beat_tag", 512'(dst_req_tag), 512'({t, b}));
      check_eq("rd_beat_byteen", 512'(dst_req_byteen), 512'(16'hFFFF));
      step();
    end
    dst_req_ready = 1'b0;
  endtask

  // Return one line of four beats in order
  task automatic return_line(input logic [7:0] t, input logic [31:0] s);
    for (int i = 0; i < 4; i++) begin
      dst_rsp_valid = 1'b1;
      dst_rsp_data  = bd(s, i);
      dst_rsp_tag   = {t, 2'(i)};
      #1;
      check_eq("rsp_beat_ready", 512'(dst_rsp_ready), 512'(1));
      if (i == 3) check_eq("rsp_not_early", 512'(src_rsp_valid), 512'(0));
      step();
    end
    dst_rsp_valid = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    reset          = 1'b1;
    src_req_valid  = 1'b0;
    src_req_rw     = 1'b0;
    src_req_byteen = '0;
    src_req_addr   = '0;
    src_req_data   = '0;
    src_req_tag    = '0;
    src_rsp_ready  = 1'b0;
    dst_req_ready  = 1'b0;
    dst_rsp_valid  = 1'b0;
    dst_rsp_data   = '0;
    dst_rsp_tag    = '0;
    #3;
    check_eq("rst_src_rsp_valid", 512'(src_rsp_valid), 512'(0));
    check_eq("rst_dst_req_valid", 512'(dst_req_valid), 512'(0));
    check_eq("rst_busy", 512'(busy), 512'(0));
    check_eq("rst_src_req_ready", 512'(src_req_ready), 512'(1));
    check_eq("rst_dst_rsp_ready", 512'(dst_rsp_ready), 512'(1));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // All-zero-byteen write is accepted and dropped
    src_req_valid  = 1'b1;
    src_req_rw     = 1'b1;
    src_req_byteen = '0;
    src_req_addr   = 26'h7;
    #1;
    check_eq("wz_accept", 512'(src_req_ready), 512'(1));
    step();
    src_req_valid = 1'b0;
    #1;
    check_eq("wz_no_beat", 512'(dst_req_valid), 512'(0));
    check_eq("wz_busy", 512'(busy), 512'(0));
    step();
    check_eq("wz_still_idle", 512'(src_req_ready), 512'(1));

    // Basic read, then hold the response under src backpressure
    do_read(26'h10, 8'h05);
    check_eq("rd_busy_pending", 512'(busy), 512'(1));
    return_line(8'h05, 32'hA0A0_0001);
    check_eq("rd_rsp_valid", 512'(src_rsp_valid), 512'(1));
    check_eq("rd_rsp_data", src_rsp_data, line(32'hA0A0_0001));
    check_eq("rd_rsp_tag", 512'(src_rsp_tag), 512'(8'h05));
    dst_rsp_valid = 1'b1;
    dst_rsp_data  = 128'hBAD;
    dst_rsp_tag   = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_dst_rsp_ready", 512'(dst_rsp_ready), 512'(0));
      check_eq("hold_rsp_data", src_rsp_data, line(32'hA0A0_0001));
    end
    dst_rsp_valid = 1'b0;
    src_rsp_ready = 1'b1;
    step();
    src_rsp_ready = 1'b0;
    #1;
    check_eq("rd_rsp_cleared", 512'(src_rsp_valid), 512'(0));
    check_eq("rd_idle_busy", 512'(busy), 512'(0));

    // Sparse write: only slices 1 and 3 enabled
    src_req_valid  = 1'b1;
    src_req_rw     = 1'b1;
    src_req_addr   = 26'h2;
    src_req_byteen = {16'h00F0, 16'h0000, 16'hFFFF, 16'h0000};
    src_req_data   = {128'h3333_0000_0000_0000_0000_0000_0000_3333,
                      128'h2222_0000_0000_0000_0000_0000_0000_2222,
                      128'h1111_0000_0000_0000_0000_0000_0000_1111,
                      128'h0000_5555_0000_0000_0000_0000_5555_0000};
    dst_req_ready  = 1'b1;
    #1;
    check_eq("wr_accept", 512'(src_req_ready), 512'(1));
    step();
    src_req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (dst_req_valid) begin
        check_eq("wr_rw", 512'(dst_req_rw), 512'(1));
        if (n == 0) begin
          check_eq("wr_addr0", 512'(dst_req_addr), 512'(28'h09));
          check_eq("wr_data0", 512'(dst_req_data),
                   512'(128'h1111_0000_0000_0000_0000_0000_0000_1111));
          check_eq("wr_be0", 512'(dst_req_byteen), 512'(16'hFFFF));
        end else begin
          check_eq("wr_addr1", 512'(dst_req_addr), 512'(28'h0B));
          check_eq("wr_data1", 512'(dst_req_data),
                   512'(128'h3333_0000_0000_0000_0000_0000_0000_3333));
          check_eq("wr_be1", 512'(dst_req_byteen), 512'(16'h00F0));
        end
        n++;
      end
      step();
    end
    dst_req_ready = 1'b0;
    check_eq("wr_beat_count", 512'(n), 512'(2));
    check_eq("wr_no_rsp", 512'(src_rsp_valid), 512'(0));
    check_eq("wr_busy", 512'(busy), 512'(0));

    // Read with toggling dst_req_ready: beat index advances only on a fire
    src_req_valid  = 1'b1;
    src_req_rw     = 1'b0;
    src_req_addr   = 26'h3;
    src_req_tag    = 8'h7A;
    src_req_byteen = '1;
    step();
    src_req_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      dst_req_ready = c[0];
      #1;
      check_eq("bp_valid", 512'(dst_req_valid), 512'(1));
      check_eq("bp_addr", 512'(dst_req_addr), 512'({26'h3, 2'(k)}));
      check_eq("bp_tag", 512'(dst_req_tag), 512'({8'h7A, 2'(k)}));
      if (dst_req_ready) k++;
      step();
    end
    dst_req_ready = 1'b0;
    check_eq("bp_beats", 512'(k), 512'(4));
    return_line(8'h7A, 32'h5EED_0002);
    check_eq("bp_rsp_data", src_rsp_data, line(32'h5EED_0002));
    check_eq("bp_rsp_tag", 512'(src_rsp_tag), 512'(8'h7A));

    // New read and response consumption in the same cycle with pending=1
    src_req_valid = 1'b1;
    src_req_addr  = 26'h5;
    src_req_tag   = 8'h11;
    src_rsp_ready = 1'b1;
    #1;
    check_eq("sim_accept", 512'(src_req_ready), 512'(1));
    step();
    src_req_valid = 1'b0;
    src_rsp_ready = 1'b0;
    #1;
    check_eq("sim_pending", 512'(dut.pending_q), 512'(1));
    check_eq("sim_busy", 512'(busy), 512'(1));
    check_eq("sim_rsp_cleared", 512'(src_rsp_valid), 512'(0));
    dst_req_ready = 1'b1;
    repeat (4) step();
    dst_req_ready = 1'b0;
    return_line(8'h11, 32'h0000_0B0B);
    check_eq("sim_rsp_data", src_rsp_data, line(32'h0000_0B0B));
    check_eq("sim_rsp_tag", 512'(src_rsp_tag), 512'(8'h11));
    src_rsp_ready = 1'b1;
    step();
    src_rsp_ready = 1'b0;
    check_eq("sim_drained_busy", 512'(busy), 512'(0));

    // Pending limit: third read waits until the first response fires
    do_read(26'h20, 8'h01);
    do_read(26'h21, 8'h02);
    src_req_valid = 1'b1;
    src_req_rw    = 1'b0;
    src_req_addr  = 26'h22;
    src_req_tag   = 8'h03;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lim_blocked", 512'(src_req_ready), 512'(0));
      step();
    end
    return_line(8'h01, 32'h0000_00A1);
    check_eq("lim_rsp_data", src_rsp_data, line(32'h0000_00A1));
    check_eq("lim_rsp_tag", 512'(src_rsp_tag), 512'(8'h01));
    src_rsp_ready = 1'b1;
    #1;
    check_eq("lim_still_blocked", 512'(src_req_ready), 512'(0));
    step();
    src_rsp_ready = 1'b0;
    #1;
    check_eq("lim_unblocked", 512'(src_req_ready), 512'(1));
    step();
    src_req_valid = 1'b0;

    // Reset after two of four beats of the third read
    dst_req_ready = 1'b1;
    #1;
    check_eq("mid_beat0", 512'(dst_req_addr), 512'({26'h22, 2'd0}));
    step();
    check_eq("mid_beat1", 512'(dst_req_addr), 512'({26'h22, 2'd1}));
    step();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_dst_valid", 512'(dst_req_valid), 512'(0));
    check_eq("mid_rst_rsp_valid", 512'(src_rsp_valid), 512'(0));
    check_eq("mid_rst_busy", 512'(busy), 512'(0));
    step();
    reset         = 1'b0;
    dst_req_ready = 1'b0;
    src_req_valid = 1'b1;
    src_req_addr  = 26'h33;
    src_req_tag   = 8'h44;
    #1;
    check_eq("post_rst_accept", 512'(src_req_ready), 512'(1));
    step();
    src_req_valid = 1'b0;
    #1;
    check_eq("post_rst_addr", 512'(dst_req_addr), 512'({26'h33, 2'd0}));
    check_eq("post_rst_tag", 512'(dst_req_tag), 512'({8'h44, 2'd0}));
    check_eq("post_rst_pending", 512'(dut.pending_q), 512'(1));
    check_eq("post_rst_busy", 512'(busy), 512'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
